// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction over req/ack,
// issues it to the decoder over valid/ready, applies PC-relative branches and stops on HALT.
module fetch_unit #(
   parameter int                ADDR_W      = 8,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter logic [3:0]        HALT_OPCODE = 4'b0001
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [15:0]       imem_rdata,
   output logic [15:0]       INST,
   output logic              inst_valid,
   input  logic              inst_ready,
   input  logic              br_taken,
   input  logic [5:0]        br_off,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] pc_p0, pc_next;
   logic [15:0]       inst_p0, inst_next;

   // Sequential successor of cur, optionally displaced by a sign-extended 6-bit offset;
   // the sum wraps silently modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] cur,
                                                 input logic              taken,
                                                 input logic signed [5:0] off);
      logic signed [ADDR_W-1:0] ext;
      ext = {{(ADDR_W-6){off[5]}}, off};
      if (taken)
         return cur + ADDR_W'(1) + ext;
      else
         return cur + ADDR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pc_p0   <= RESET_PC;
         inst_p0 <= '0;
      end else begin
         state   <= state_next;
         pc_p0   <= pc_next;
         inst_p0 <= inst_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc_p0;
      inst_next  = inst_p0;
      case (state)
         IDLE:   state_next = FETCH;
         FETCH: begin
            if (imem_ack) begin
               // A HALT word is swallowed: it is never issued and pc stays on it.
               if (imem_rdata[15:12] == HALT_OPCODE) begin
                  state_next = HALTED;
               end else begin
                  state_next = ISSUE;
                  inst_next  = imem_rdata;
               end
            end
         end
         ISSUE: begin
            if (inst_ready) begin
               state_next = FETCH;
               pc_next    = next_pc(pc_p0, br_taken, br_off);
            end
         end
         HALTED: state_next = HALTED;
         default: state_next = IDLE;
      endcase
   end

   assign imem_req   = (state == FETCH);
   assign imem_addr  = pc_p0;
   assign inst_valid = (state == ISSUE);
   assign halted     = (state == HALTED);
   assign INST       = inst_p0;
   assign pc         = pc_p0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic checked against a
// transaction-level PC model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] INST;
   logic        inst_valid;
   logic        inst_ready;
   logic        br_taken;
   logic [5:0]  br_off;
   logic [7:0]  pc;
   logic        halted;

   int checks = 0;
   int passed = 0;
   logic [7:0] model_pc;

   fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .HALT_OPCODE(4'b0001)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .INST(INST), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .br_taken(br_taken), .br_off(br_off), .pc(pc), .halted(halted)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic [7:0] model_next(input logic [7:0] cur, input logic taken,
                                             input logic [5:0] off);
      int o, m;
      o = off[5] ? int'(off) - 64 : int'(off);
      m = int'(cur) + 1 + (taken ? o : 0);
      m = ((m % 256) + 256) % 256;
      return 8'(m);
   endfunction

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:12] == 4'b0001) w[15:12] = 4'b0010;
      return w;
   endfunction

   task automatic do_reset();
      rst = 1'b1; imem_ack = 0; inst_ready = 0; br_taken = 0; br_off = 0; imem_rdata = 0;
      step(); step();
      rst = 1'b0;
      model_pc = 8'h00;
   endtask

   // Waits for the request, checks its address, returns the word after 'waits' idle cycles.
   task automatic fetch_word(input logic [15:0] word, input int waits);
      for (int i = 0; i < 4 && !imem_req; i++) step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc)
         $display("FAIL fetch_req: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, model_pc);
      else passed++;
      for (int i = 0; i < waits; i++) begin
         imem_rdata = 16'($urandom);
         step();
         checks++;
         if (imem_req !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== model_pc)
            $display("FAIL fetch_wait: req=%b valid=%b addr=%h, required 1 0 %h", imem_req, inst_valid, imem_addr, model_pc);
         else passed++;
      end
      imem_ack = 1'b1; imem_rdata = word;
      step();
      imem_ack = 1'b0;
      checks++;
      if (word[15:12] == 4'b0001) begin
         if (halted !== 1'b1 || inst_valid !== 1'b0 || pc !== model_pc || imem_req !== 1'b0)
            $display("FAIL fetch_halt: halted=%b valid=%b pc=%h req=%b, required 1 0 %h 0", halted, inst_valid, pc, imem_req, model_pc);
         else passed++;
      end else begin
         if (inst_valid !== 1'b1 || INST !== word || pc !== model_pc || imem_req !== 1'b0)
            $display("FAIL fetch_issue: valid=%b INST=%h pc=%h req=%b, required 1 %h %h 0", inst_valid, INST, pc, imem_req, word, model_pc);
         else passed++;
      end
   endtask

   task automatic accept(input logic taken, input logic [5:0] off);
      inst_ready = 1'b1; br_taken = taken; br_off = off;
      step();
      inst_ready = 1'b0; br_taken = 1'b0; br_off = 6'(0);
      model_pc = model_next(model_pc, taken, off);
      checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== model_pc)
         $display("FAIL accept: valid=%b req=%b addr=%h, required 0 1 %h", inst_valid, imem_req, imem_addr, model_pc);
      else passed++;
   endtask

   // Walks the PC to target using taken branches of at most the offset range per hop.
   task automatic goto_pc(input logic [7:0] target);
      int d;
      for (int n = 0; n < 20 && model_pc != target; n++) begin
         d = int'(target) - int'(model_pc) - 1;
         d = ((d % 256) + 256) % 256;
         if (d >= 128) d = d - 256;
         if (d > 31) d = 31;
         if (d < -32) d = -32;
         fetch_word(rand_word(), 0);
         accept(1'b1, 6'(d));
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (imem_req !== 0 || inst_valid !== 0 || halted !== 0 || pc !== 8'h00 || INST !== 16'h0)
         $display("FAIL reset_state: req=%b valid=%b halted=%b pc=%h INST=%h, required all zero",
                  imem_req, inst_valid, halted, pc, INST);
      else passed++;
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00)
         $display("FAIL reset_first_req: req=%b addr=%h, required 1 00", imem_req, imem_addr);
      else passed++;
   endtask

   task automatic test_sequential();
      fetch_word(16'h8A53, 2);
      checks++;
      if (pc !== 8'h00) $display("FAIL seq_pc: pc=%h, required 00", pc);
      else passed++;
      accept(1'b0, 6'h15);
      checks++;
      if (imem_addr !== 8'h01) $display("FAIL seq_next_addr: addr=%h, required 01", imem_addr);
      else passed++;
   endtask

   task automatic test_backpressure();
      logic [15:0] w;
      w = rand_word();
      fetch_word(w, 1);
      for (int i = 0; i < 5; i++) begin
         imem_ack = 1'($urandom); br_taken = 1'($urandom); br_off = 6'($urandom);
         imem_rdata = 16'($urandom);
         step();
         checks++;
         if (INST !== w || pc !== model_pc || inst_valid !== 1'b1 || imem_req !== 1'b0)
            $display("FAIL backpressure: INST=%h pc=%h valid=%b req=%b, required %h %h 1 0", INST, pc, inst_valid, imem_req, w, model_pc);
         else passed++;
      end
      imem_ack = 0; br_taken = 0; br_off = 0;
      accept(1'b0, 6'h00);
   endtask

   task automatic test_branch();
      goto_pc(8'h10);
      fetch_word(rand_word(), 0);
      accept(1'b1, 6'b111100);
      checks++;
      if (imem_addr !== 8'h0D) $display("FAIL branch_back: addr=%h, required 0D", imem_addr);
      else passed++;
      goto_pc(8'h02);
      fetch_word(rand_word(), 1);
      accept(1'b1, 6'b111100);
      checks++;
      if (imem_addr !== 8'hFF) $display("FAIL branch_wrap_down: addr=%h, required FF", imem_addr);
      else passed++;
      goto_pc(8'hFE);
      fetch_word(rand_word(), 0);
      accept(1'b1, 6'd5);
      checks++;
      if (imem_addr !== 8'h04) $display("FAIL branch_wrap_up: addr=%h, required 04", imem_addr);
      else passed++;
      goto_pc(8'hFF);
      fetch_word(rand_word(), 0);
      accept(1'b0, 6'd0);
      checks++;
      if (imem_addr !== 8'h00) $display("FAIL seq_wrap: addr=%h, required 00", imem_addr);
      else passed++;
   endtask

   task automatic test_halt();
      goto_pc(8'h07);
      fetch_word(16'h1000, 1);
      for (int i = 0; i < 20; i++) begin
         imem_ack = 1'($urandom); inst_ready = 1'($urandom); br_taken = 1'($urandom);
         br_off = 6'($urandom); imem_rdata = rand_word();
         step();
         checks++;
         if (halted !== 1'b1 || inst_valid !== 1'b0 || pc !== 8'h07 || imem_req !== 1'b0)
            $display("FAIL halt_hold: halted=%b valid=%b pc=%h req=%b, required 1 0 07 0", halted, inst_valid, pc, imem_req);
         else passed++;
      end
      do_reset();
      checks++;
      if (halted !== 1'b0 || pc !== 8'h00) $display("FAIL halt_reset: halted=%b pc=%h, required 0 00", halted, pc);
      else passed++;
   endtask

   task automatic test_reset_mid_fetch();
      fetch_word(rand_word(), 0);
      accept(1'b1, 6'd9);
      step();
      rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h8A53;
      step();
      rst = 1'b0; imem_ack = 1'b0;
      model_pc = 8'h00;
      checks++;
      if (INST !== 16'h0 || inst_valid !== 1'b0 || pc !== 8'h00 || imem_req !== 1'b0)
         $display("FAIL reset_mid_fetch: INST=%h valid=%b pc=%h req=%b, required 0000 0 00 0", INST, inst_valid, pc, imem_req);
      else passed++;
      inst_ready = 1'b1; br_taken = 1'b1; br_off = 6'd12;
      step(); step();
      inst_ready = 1'b0; br_taken = 1'b0; br_off = 6'd0;
      checks++;
      if (pc !== 8'h00 || imem_addr !== 8'h00 || imem_req !== 1'b1)
         $display("FAIL ignored_branch: pc=%h addr=%h req=%b, required 00 00 1", pc, imem_addr, imem_req);
      else passed++;
   endtask

   task automatic test_random();
      int stall;
      for (int n = 0; n < 40; n++) begin
         fetch_word(rand_word(), int'($urandom_range(0, 3)));
         stall = int'($urandom_range(0, 2));
         for (int i = 0; i < stall; i++) begin
            br_taken = 1'($urandom); imem_ack = 1'($urandom);
            step();
            checks++;
            if (inst_valid !== 1'b1 || pc !== model_pc)
               $display("FAIL random_stall: valid=%b pc=%h, required 1 %h", inst_valid, pc, model_pc);
            else passed++;
         end
         br_taken = 0; imem_ack = 0;
         accept(1'($urandom), 6'($urandom));
      end
   endtask

   initial begin
      rst = 1'b1; imem_ack = 0; imem_rdata = 0; inst_ready = 0; br_taken = 0; br_off = 0;
      model_pc = 8'h00;
      step();
      test_reset();
      test_sequential();
      test_backpressure();
      test_branch();
      test_halt();
      test_reset_mid_fetch();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
